// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the MIPS core, sitting directly upstream of the
// opcode decoder. Holds the PC, issues fetches over a req/ready handshake and
// registers the fetched word plus pc+4 into the IF/ID register. A one-entry
// skid buffer absorbs a response that arrives while ID is stalled. Jump and
// taken-branch redirects from downstream steer the PC; a response belonging
// to the abandoned path is discarded.
//
// Ports:
//   clk, rst_n                   rising-edge clock, async active-low reset
//   imem_req / imem_addr         fetch request, address held until accepted
//   imem_ready / imem_rdata      response strobe and instruction word
//   stall                        ID cannot accept; IF/ID and PC hold
//   jump / branch_taken          redirects for the instruction in IF/ID
//   branch_target                branch destination from the datapath
//   instr / opcode / pc_plus4    IF/ID contents (opcode = instr[31:26])
//   instr_valid                  0 = bubble, instr forced to 32'h0
//
// Build option:
//   IF_BRANCH_DELAY_SLOT_EN  when defined, the instruction after a branch or
//                            jump (the delay slot) is delivered instead of
//                            squashed, and fetch then continues at the target.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              instr_valid
);

`ifdef IF_BRANCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT_EN = 1'b1;
`else
  localparam bit DELAY_SLOT_EN = 1'b0;
`endif

  // FULL: skid buffer occupied, no request. KILL: waiting to discard the
  // response of a request issued on the abandoned path.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    KILL  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic              slot_pend_q, slot_pend_d;
  logic [ADDR_W-1:0] slot_target_q, slot_target_d;

  logic              redirect;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] seq_next;

  assign pc_inc          = pc_q + ADDR_W'(4);
  assign jump_target     = {pc_plus4_q[ADDR_W-1:ADDR_W-4], instr_q[25:0], 2'b00};
  // Stall masks redirects; the decoder presents them again once it clears.
  assign redirect        = valid_q && !stall && (jump || branch_taken);
  assign redirect_target = jump ? jump_target : branch_target;
  // A pending delay-slot redirect replaces the sequential successor.
  assign seq_next        = slot_pend_q ? slot_target_q : pc_inc;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_addr_d   = hold_addr_q;
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    slot_pend_d   = slot_pend_q;
    slot_target_d = slot_target_q;

    // ID consumes IF/ID whenever it is not stalled; without a new word the
    // register turns into a bubble so nothing is issued twice.
    if (!stall) begin
      valid_d = 1'b0;
      instr_d = 32'h0;
    end

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        if (imem_ready) begin
          slot_pend_d = 1'b0;
          if (redirect && !DELAY_SLOT_EN) begin
            // Word belongs to the old path: drop it and restart at target.
            pc_d = redirect_target;
          end else begin
            pc_d = redirect ? redirect_target : seq_next;
            if (stall) begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_inc;
              state_d      = FULL;
            end else begin
              instr_d    = imem_rdata;
              pc_plus4_d = pc_inc;
              valid_d    = 1'b1;
            end
          end
        end else if (redirect) begin
          if (DELAY_SLOT_EN) begin
            slot_pend_d   = 1'b1;
            slot_target_d = redirect_target;
          end else begin
            // Keep the outstanding address stable until its response arrives.
            hold_addr_d = pc_q;
            pc_d        = redirect_target;
            state_d     = KILL;
          end
        end
      end

      FULL: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = FETCH;
          if (DELAY_SLOT_EN) begin
            instr_d    = skid_instr_q;
            pc_plus4_d = skid_pc4_q;
            valid_d    = 1'b1;
          end
        end else if (!stall) begin
          instr_d    = skid_instr_q;
          pc_plus4_d = skid_pc4_q;
          valid_d    = 1'b1;
          state_d    = FETCH;
        end
      end

      KILL: begin
        if (imem_ready) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

  // Single state/datapath register; everything returns to reset values
  // immediately, abandoning any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      hold_addr_q   <= RESET_PC;
      instr_q       <= 32'h0;
      pc_plus4_q    <= '0;
      valid_q       <= 1'b0;
      skid_instr_q  <= 32'h0;
      skid_pc4_q    <= '0;
      slot_pend_q   <= 1'b0;
      slot_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_addr_q   <= hold_addr_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
      valid_q       <= valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
      slot_pend_q   <= slot_pend_d;
      slot_target_q <= slot_target_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr   = (state_q == KILL) ? hold_addr_q : pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc_plus4    = pc_plus4_q;
  assign instr_valid = valid_q;

endmodule
